// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl -- serialises one LED strip frame (start, per-LED, end segments) to a byte writer.
// Revision 1.0
`default_nettype none

module led_frame_ctrl #(
  parameter int NUM_LEDS    = 8,
  parameter int END_BYTES   = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic        ctl_clk,
  input  logic        ctl_reset_n,
  input  logic        frame_go,
  input  logic [4:0]  global_bright,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        pix_rd_en,
  output logic [7:0]  pix_addr,
  input  logic [23:0] pix_data,
  output logic        spi_start,
  output logic [7:0]  spi_data_in,
  input  logic        spi_busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_FETCH     = 4'd2,
    S_CAPTURE   = 4'd3,
    S_ISSUE     = 4'd4,
    S_WAIT_ACK  = 4'd5,
    S_WAIT_DONE = 4'd6,
    S_NEXT      = 4'd7,
    S_FINISH    = 4'd8
  } state_t;

  localparam logic [1:0] c_SEG_START = 2'd0;
  localparam logic [1:0] c_SEG_LED   = 2'd1;
  localparam logic [1:0] c_SEG_END   = 2'd2;
  localparam logic [7:0] c_LED_LAST  = 8'(NUM_LEDS - 1);
  localparam logic [3:0] c_END_LAST  = 4'(END_BYTES - 1);
  localparam int         c_AW        = $clog2(ACK_TIMEOUT + 1) + 1;
  localparam logic [c_AW-1:0] c_ACK_LIMIT = c_AW'(ACK_TIMEOUT);

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_seg, w_seg_nxt;
  logic [3:0]      r_byte, w_byte_nxt;
  logic [7:0]      r_led, w_led_nxt;
  logic [4:0]      r_bright;
  logic [23:0]     r_pix;
  logic [7:0]      r_spi_data, w_byte_val;
  logic [c_AW-1:0] r_ack_cnt;
  logic            r_err, w_set_err;

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = r_seg;
    w_byte_nxt  = r_byte;
    w_led_nxt   = r_led;
    w_set_err   = 1'b0;
    frame_busy  = 1'b0;
    frame_done  = 1'b0;
    pix_rd_en   = 1'b0;
    spi_start   = 1'b0;
    case (r_state)
      S_IDLE: if (frame_go) w_state_nxt = S_LOAD;
      S_LOAD: begin
        frame_busy  = 1'b1;
        w_seg_nxt   = c_SEG_START;
        w_byte_nxt  = 4'd0;
        w_led_nxt   = 8'd0;
        w_state_nxt = S_ISSUE;
      end
      S_FETCH: begin
        frame_busy  = 1'b1;
        pix_rd_en   = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        frame_busy  = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        frame_busy  = 1'b1;
        spi_start   = 1'b1;
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        frame_busy = 1'b1;
        if (spi_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_ack_cnt >= c_ACK_LIMIT) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_FINISH;
        end
      end
      S_WAIT_DONE: begin
        frame_busy = 1'b1;
        if (!spi_busy) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        frame_busy  = 1'b1;
        w_state_nxt = S_ISSUE;
        w_byte_nxt  = r_byte + 4'd1;
        case (r_seg)
          c_SEG_START: if (r_byte == 4'd3) begin
            w_seg_nxt   = c_SEG_LED;
            w_byte_nxt  = 4'd0;
            w_state_nxt = S_FETCH;
          end
          c_SEG_LED: if (r_byte == 4'd3) begin
            w_byte_nxt = 4'd0;
            if (r_led == c_LED_LAST) begin
              w_seg_nxt = c_SEG_END;
            end else begin
              w_led_nxt   = r_led + 8'd1;
              w_state_nxt = S_FETCH;
            end
          end
          default: if (r_byte == c_END_LAST) w_state_nxt = S_FINISH;
        endcase
      end
      S_FINISH: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte that the next ISSUE cycle will present, derived from the next-cycle position.
  always_comb begin
    w_byte_val = 8'h00;
    case (w_seg_nxt)
      c_SEG_LED: begin
        case (w_byte_nxt[1:0])
          2'd0:    w_byte_val = {3'b111, r_bright};
          2'd1:    w_byte_val = r_pix[7:0];
          2'd2:    w_byte_val = r_pix[15:8];
          default: w_byte_val = r_pix[23:16];
        endcase
      end
      c_SEG_END: w_byte_val = 8'hFF;
      default:   w_byte_val = 8'h00;
    endcase
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      r_seg      <= c_SEG_START;
      r_byte     <= 4'd0;
      r_led      <= 8'd0;
      r_bright   <= 5'd0;
      r_pix      <= 24'd0;
      r_spi_data <= 8'd0;
      r_ack_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_seg  <= w_seg_nxt;
      r_byte <= w_byte_nxt;
      r_led  <= w_led_nxt;
      if (r_state == S_LOAD)    r_bright <= global_bright;
      if (r_state == S_CAPTURE) r_pix    <= pix_data;
      if (w_state_nxt == S_ISSUE) r_spi_data <= w_byte_val;
      if (r_state == S_ISSUE)         r_ack_cnt <= c_AW'(1);
      else if (r_state == S_WAIT_ACK) r_ack_cnt <= r_ack_cnt + c_AW'(1);
      if (r_state == S_LOAD) r_err <= 1'b0;
      else if (w_set_err)    r_err <= 1'b1;
    end
  end

  assign frame_err   = r_err;
  assign pix_addr    = r_led;
  assign spi_data_in = r_spi_data;

endmodule

`default_nettype wire

// File: doc/led_frame_ctrl.md
LED_FRAME_CTRL -- requirements
Module: led_frame_ctrl

Interface
REQ-001 Parameter NUM_LEDS, default 8, meaning LEDs per strip (1..255).
REQ-002 Parameter END_BYTES, default 4, meaning count of 0xFF end-frame bytes (1..15).
REQ-003 Parameter ACK_TIMEOUT, default 4, meaning max clocks from spi_start pulse to spi_busy high.
REQ-004 Ports SHALL be, in this order:
- ctl_clk  in  1  sole clock, all logic on rising edge.
- ctl_reset_n  in  1  asynchronous active-low reset.
- frame_go  in  1  request one full strip refresh.
- global_bright  in  5  brightness for every LED in the frame.
- frame_busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_err  out  1  sticky handshake-timeout flag.
- pix_rd_en  out  1  pixel read strobe.
- pix_addr  out  8  LED index being read.
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}, valid one clock after pix_rd_en.
- spi_start  out  1  byte-writer start pulse.
- spi_data_in  out  8  byte to the byte writer.
- spi_busy  in  1  byte-writer busy.

Function
REQ-005 Byte stream per frame SHALL be: 4 x 0x00 start; per LED i=0..NUM_LEDS-1: {3'b111,bright}, B, G, R; then END_BYTES x 0xFF.
REQ-006 States SHALL be IDLE, LOAD, FETCH, CAPTURE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
REQ-007 IDLE: frame_go=1 -> LOAD; frame_busy=1 from the following cycle; frame_go while frame_busy=1 SHALL be ignored (not queued).
REQ-008 LOAD SHALL latch global_bright into a frame-local register, clear byte and LED counters, clear frame_err, and select the start-frame segment.
REQ-009 FETCH (entered at byte 0 of each LED) SHALL assert pix_rd_en for exactly one cycle with pix_addr=LED index; CAPTURE SHALL register pix_data on the next cycle.
REQ-010 ISSUE SHALL assert spi_start for exactly one cycle with spi_data_in set to the current byte.
REQ-011 spi_data_in SHALL hold stable from ISSUE until WAIT_DONE exits.
REQ-012 WAIT_ACK SHALL wait for spi_busy=1, then go to WAIT_DONE; WAIT_DONE SHALL wait for spi_busy=0, then go to NEXT.
REQ-013 If spi_busy is not high within ACK_TIMEOUT clocks of the ISSUE cycle, the block SHALL set frame_err=1 and go to FINISH.
REQ-014 NEXT SHALL advance the byte count within the segment; segment order is start -> LED (FETCH at each LED's byte 0) -> end -> FINISH.
REQ-015 pix_addr SHALL wrap to 0 only via LOAD; it never exceeds NUM_LEDS-1.
REQ-016 FINISH SHALL pulse frame_done for one cycle, drop frame_busy, and return to IDLE.
REQ-017 frame_go asserted in the FINISH cycle SHALL be ignored; frame_go in the next cycle (IDLE) SHALL be accepted.
REQ-018 global_bright changes mid-frame SHALL NOT affect the current frame.
REQ-019 Total spi_start pulses per error-free frame SHALL equal 4 + 4*NUM_LEDS + END_BYTES.
REQ-020 Unreachable state encodings SHALL return to IDLE with spi_start=0.

Reset
REQ-021 ctl_reset_n=0 SHALL immediately force IDLE and set to 0: frame_busy, frame_done, frame_err, pix_rd_en, pix_addr, spi_start, spi_data_in, all counters, and all holding registers.
REQ-022 Reset mid-frame SHALL abandon the frame with no frame_done pulse; after release the block waits for a new frame_go.

Verification
REQ-023 Bench SHALL cover the following directed scenarios:
- NUM_LEDS=2, END_BYTES=4, bright=5'h1F, pixels {0x112233, 0x445566}, writer model busy 1 clk after start for 10 clks -> bytes 00 00 00 00 FF 33 22 11 FF 66 55 44 FF FF FF FF, one frame_done pulse, frame_err=0.
- frame_go pulsed every cycle during a frame -> exactly one frame produced.
- Writer model never asserts busy -> frame_err=1 after ACK_TIMEOUT, frame_done pulses, 1 spi_start seen.
- Reset asserted during LED byte 2 -> all outputs 0 the same cycle; next frame_go gives a full correct stream from 0x00.
- global_bright changed 5'h03 -> 5'h1A mid-frame -> all LED header bytes 0xE3; next frame uses 0xFA.
- NUM_LEDS=1, END_BYTES=1 -> 9 spi_start pulses; pix_rd_en pulses exactly once, with pix_addr=0.
